// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-word adder that ripples one 4-bit slice per clock, LSB nibble first,
// holding the registered carry between nibbles and presenting the result with a valid/ready handshake.
module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [3:0]    slice_s;
    logic          slice_c;

    full_adder_4bit u_slice (
        .a    (a_q[4*idx_q +: 4]),
        .b    (b_q[4*idx_q +: 4]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                idx_d   = '0;
                sum_d   = '0;
                cout_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = slice_s;
                carry_d             = slice_c;
                // idx parks on the top nibble so it never leaves 0..NIBBLES-1
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = slice_c;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks of the serial adder against
// plain a+b+cin arithmetic, for a 4-nibble and a 1-nibble instance.
module tb_nibble_serial_adder;
    localparam int N4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, busy1;
    logic [3:0]  sum1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    bit have_last = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(.NIBBLES(N4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the result is consumed.
    task automatic txn4(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input int hold, input bit rnd_rdy);
        logic [16:0] exp;
        int w;
        exp = 17'(ta) + 17'(tb) + 17'(tc);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", in_ready, 1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        if (have_last) check("accept_spacing", 64'((cyc - last_acc) >= N4 + 2), 1);
        last_acc = cyc;
        have_last = 1;
        for (int k = 0; k < N4; k++) begin
            @(negedge clk);
            check("run_out_valid", out_valid, 0);
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            if (rnd_rdy) out_ready = 1'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("done_out_valid", out_valid, 1);
        check("done_sum", sum, exp[15:0]);
        check("done_cout", cout, exp[16]);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", sum, exp[15:0]);
            check("hold_cout", cout, exp[16]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_out_valid", out_valid, 0);
        check("consumed_in_ready", in_ready, 1);
        check("consumed_busy", busy, 0);
    endtask

    task automatic txn1(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        logic [4:0] exp;
        exp = 5'(ta) + 5'(tb) + 5'(tc);
        check("n1_in_ready", in_ready1, 1);
        a1 = ta; b1 = tb; cin1 = tc; in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        a1 = 4'($urandom); b1 = 4'($urandom);
        @(negedge clk);
        check("n1_run_out_valid", out_valid1, 0);
        @(negedge clk);
        check("n1_done_out_valid", out_valid1, 1);
        check("n1_result", {cout1, sum1}, exp);
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn4(16'hFFFF, 16'h0001, 1'b0, 0, 0);
        txn4(16'h1234, 16'h4321, 1'b1, 2, 0);
        txn4(16'h8000, 16'h8000, 1'b0, 10, 0);
        txn4(16'h0000, 16'h0000, 1'b0, 0, 1);
        txn4(16'hFFFF, 16'hFFFF, 1'b1, 1, 1);

        // abort two cycles into a run
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        have_last = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_stale", out_valid, 0);
        end

        for (int x = 0; x < 512; x++) txn1(4'(x), 4'(x >> 4), 1'(x >> 8));

        for (int t = 0; t < 1000; t++)
            txn4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule
